// File: rtl/axis_order_serializer_if.sv
// Record-in / beat-out bus of the order serializer.
// master: the serializer itself; slave: the record source and beat sink around it.
interface axis_order_serializer_if #(
    parameter int WIDTH = 64,
    parameter int BEATS = 4,
    parameter int CNT_W = 16
) ();
    localparam int NB_W = $clog2(BEATS) + 1;

    logic                   rec_valid;
    logic                   rec_ready;
    logic [WIDTH*BEATS-1:0] rec_data;
    logic [NB_W-1:0]        rec_beats;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic                   out_last;
    logic [CNT_W-1:0]       frame_cnt;

    modport master (
        input  rec_valid, rec_data, rec_beats, out_ready,
        output rec_ready, out_valid, out_data, out_last, frame_cnt
    );

    modport slave (
        output rec_valid, rec_data, rec_beats, out_ready,
        input  rec_ready, out_valid, out_data, out_last, frame_cnt
    );
endinterface

// File: rtl/axis_order_serializer.sv
// Order record serializer: captures one WIDTH*BEATS record per handshake and
// emits it as 1..BEATS WIDTH-bit beats with out_last on the final beat.
// A new record can be taken on the same edge as the final beat is accepted,
// so consecutive records stream with no idle cycle between them.
module axis_order_serializer #(
    parameter int WIDTH = 64,
    parameter int BEATS = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    axis_order_serializer_if.master  bus
);
    localparam int NB_W  = $clog2(BEATS) + 1;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t                 r_state;
    logic [WIDTH*BEATS-1:0] r_hold;
    logic [IDX_W-1:0]       r_idx;
    logic [NB_W-1:0]        r_nbeats;
    logic                   r_out_valid;
    logic                   r_out_last;
    logic [WIDTH-1:0]       r_out_data;
    logic [CNT_W-1:0]       r_frame_cnt;

    logic                   w_fire;
    logic                   w_done;
    logic                   w_rec_ready;
    logic                   w_accept;
    logic [NB_W-1:0]        w_nbeats;
    logic [IDX_W-1:0]       w_next_idx;
    logic                   w_next_last;
    logic [WIDTH-1:0]       w_next_data;

    // Handshake qualifiers: a beat leaves on w_fire, the record completes on w_done.
    assign w_fire      = r_out_valid && bus.out_ready;
    assign w_done      = w_fire && r_out_last;
    assign w_rec_ready = (r_state == S_IDLE) || w_done;
    assign w_accept    = bus.rec_valid && w_rec_ready;

    // Zero or oversized beat counts mean "send the full record".
    assign w_nbeats = ((bus.rec_beats == NB_W'(0)) || (bus.rec_beats > NB_W'(BEATS)))
                      ? NB_W'(BEATS) : bus.rec_beats;

    // Next beat is pre-selected from the hold register so out_data stays registered.
    assign w_next_idx  = r_idx + IDX_W'(1);
    assign w_next_last = (NB_W'(w_next_idx) == (r_nbeats - NB_W'(1)));
    assign w_next_data = r_hold[w_next_idx*WIDTH +: WIDTH];

    // Serializer FSM: capture, beat advance, record completion and frame counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_hold      <= '0;
            r_idx       <= '0;
            r_nbeats    <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_frame_cnt <= '0;
        end else begin
            if (w_done) begin
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end

            case (r_state)
                S_IDLE, S_SEND: begin
                    if (w_accept) begin
                        // Fresh record: beat 0 goes out on the very next cycle.
                        r_state     <= S_SEND;
                        r_hold      <= bus.rec_data;
                        r_nbeats    <= w_nbeats;
                        r_idx       <= '0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= bus.rec_data[WIDTH-1:0];
                        r_out_last  <= (w_nbeats == NB_W'(1));
                    end else if (w_done) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                    end else if (w_fire) begin
                        r_idx       <= w_next_idx;
                        r_out_data  <= w_next_data;
                        r_out_last  <= w_next_last;
                    end else begin
                        // Idle, or stalled by the sink: hold everything.
                        r_state     <= r_state;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rec_ready = w_rec_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.frame_cnt = r_frame_cnt;
endmodule
